// File: rtl/uart_io_nios2_qsys_div_cell_if.sv
// Handshake/operand bundle between the Nios II A-stage and the divide cell.
// A_div_rem exists only when DIV_CELL_REM_EN is defined.
interface uart_io_nios2_qsys_div_cell_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A_div_src1;
    logic [WIDTH-1:0] A_div_src2;
    logic             A_div_signed;
    logic             A_div_start;
    logic             A_div_busy;
    logic             A_div_done;
    logic [WIDTH-1:0] A_div_result;
`ifdef DIV_CELL_REM_EN
    logic [WIDTH-1:0] A_div_rem;

    modport master (
        output A_div_src1, A_div_src2, A_div_signed, A_div_start,
        input  A_div_busy, A_div_done, A_div_result, A_div_rem
    );
    modport slave (
        input  A_div_src1, A_div_src2, A_div_signed, A_div_start,
        output A_div_busy, A_div_done, A_div_result, A_div_rem
    );
`else
    modport master (
        output A_div_src1, A_div_src2, A_div_signed, A_div_start,
        input  A_div_busy, A_div_done, A_div_result
    );
    modport slave (
        input  A_div_src1, A_div_src2, A_div_signed, A_div_start,
        output A_div_busy, A_div_done, A_div_result
    );
`endif
endinterface

// File: rtl/uart_io_nios2_qsys_div_cell.sv
// Sequential radix-2 restoring 32-bit DIV/DIVU cell, fixed 35-cycle latency.
// Define DIV_CELL_REM_EN to compile in the remainder output and its sign fix.
module uart_io_nios2_qsys_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    uart_io_nios2_qsys_div_cell_if.slave    div_if
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_src1;
    logic [WIDTH-1:0] r_src2;
    logic             r_signed;
    logic             r_neg_q;
    logic             r_dz;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [4:0]       r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

`ifdef DIV_CELL_REM_EN
    logic             r_neg_r;
    logic [WIDTH-1:0] r_rem_out;
`endif

    function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE) : v;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; start is only honoured in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (div_if.A_div_start) begin
                    w_next_state = ST_PREP;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_PREP: w_next_state = ST_CALC;
            ST_CALC: begin
                if (r_cnt == 5'd31) begin
                    w_next_state = ST_FIX;
                end else begin
                    w_next_state = ST_CALC;
                end
            end
            ST_FIX:  w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // One restoring step: remainder never exceeds the divisor, so 32 bits hold it
    always_comb begin
        w_shift    = {r_rem, r_quo[WIDTH-1]};
        w_trial    = w_shift - {1'b0, r_div};
        w_rem_next = w_shift[WIDTH-1:0];
        w_quo_next = {r_quo[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH]) begin
            w_rem_next = w_trial[WIDTH-1:0];
            w_quo_next = {r_quo[WIDTH-2:0], 1'b1};
        end else begin
            w_rem_next = w_shift[WIDTH-1:0];
            w_quo_next = {r_quo[WIDTH-2:0], 1'b0};
        end
    end

    // Operand capture, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src1    <= {WIDTH{1'b0}};
            r_src2    <= {WIDTH{1'b0}};
            r_signed  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_dz      <= 1'b0;
            r_div     <= {WIDTH{1'b0}};
            r_rem     <= {WIDTH{1'b0}};
            r_quo     <= {WIDTH{1'b0}};
            r_cnt     <= 5'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= {WIDTH{1'b0}};
`ifdef DIV_CELL_REM_EN
            r_neg_r   <= 1'b0;
            r_rem_out <= {WIDTH{1'b0}};
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (div_if.A_div_start) begin
                        r_src1   <= div_if.A_div_src1;
                        r_src2   <= div_if.A_div_src2;
                        r_signed <= div_if.A_div_signed;
                        r_neg_q  <= div_if.A_div_signed &
                                    (div_if.A_div_src1[WIDTH-1] ^ div_if.A_div_src2[WIDTH-1]);
                        r_dz     <= (div_if.A_div_src2 == {WIDTH{1'b0}});
                        r_busy   <= 1'b1;
`ifdef DIV_CELL_REM_EN
                        r_neg_r  <= div_if.A_div_signed & div_if.A_div_src1[WIDTH-1];
`endif
                    end else begin
                        r_busy   <= 1'b0;
                    end
                end
                ST_PREP: begin
                    // |0x80000000| stays 0x80000000, read as unsigned magnitude
                    r_quo <= f_cneg(r_src1, r_signed & r_src1[WIDTH-1]);
                    r_div <= f_cneg(r_src2, r_signed & r_src2[WIDTH-1]);
                    r_rem <= {WIDTH{1'b0}};
                    r_cnt <= 5'd0;
                end
                ST_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 5'd1;
                end
                ST_FIX: begin
                    r_done <= 1'b1;
                    if (r_dz) begin
                        r_result  <= {WIDTH{1'b1}};
`ifdef DIV_CELL_REM_EN
                        r_rem_out <= r_src1;
`endif
                    end else begin
                        r_result  <= f_cneg(r_quo, r_neg_q);
`ifdef DIV_CELL_REM_EN
                        r_rem_out <= f_cneg(r_rem, r_neg_r);
`endif
                    end
                end
                ST_DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign div_if.A_div_busy   = r_busy;
    assign div_if.A_div_done   = r_done;
    assign div_if.A_div_result = r_result;
`ifdef DIV_CELL_REM_EN
    assign div_if.A_div_rem    = r_rem_out;
`endif

endmodule

// File: tb/tb_uart_io_nios2_qsys_div_cell.sv
// Randomized self-checking bench for the divide cell against a 64-bit arithmetic model.
module tb_uart_io_nios2_qsys_div_cell;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    uart_io_nios2_qsys_div_cell_if #(.WIDTH(32)) dif ();

    uart_io_nios2_qsys_div_cell #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .div_if (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit division; truncating division, remainder follows dividend
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, tq, tr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[31:0];
            r  = tr[31:0];
        end
    endfunction

    task automatic randomize_ops();
        dif.A_div_src1   = $urandom;
        dif.A_div_src2   = $urandom;
        dif.A_div_signed = 1'($urandom_range(0, 1));
    endtask

    // Entered at a negedge (cycle 0); leaves at the negedge of cycle 36
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int sp1, input int sp2);
        logic [31:0] eq, er;
        ref_div(a, b, s, eq, er);
        dif.A_div_src1   = a;
        dif.A_div_src2   = b;
        dif.A_div_signed = s;
        dif.A_div_start  = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            chk("busy", {31'd0, dif.A_div_busy}, (c <= 35) ? 32'd1 : 32'd0);
            chk("done", {31'd0, dif.A_div_done}, (c == 35) ? 32'd1 : 32'd0);
            if (c >= 35) begin
                chk("result", dif.A_div_result, eq);
`ifdef DIV_CELL_REM_EN
                chk("rem", dif.A_div_rem, er);
`endif
            end
            randomize_ops();
            if (c == sp1 || c == sp2) begin
                dif.A_div_start = 1'b1;
            end else begin
                dif.A_div_start = 1'b0;
            end
        end
    endtask

    task automatic do_abort(input logic [31:0] a, input logic [31:0] b, input logic s);
        dif.A_div_src1   = a;
        dif.A_div_src2   = b;
        dif.A_div_signed = s;
        dif.A_div_start  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            dif.A_div_start = 1'b0;
            chk("abort_busy", {31'd0, dif.A_div_busy}, 32'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy0", {31'd0, dif.A_div_busy}, 32'd0);
        chk("abort_res0", dif.A_div_result, 32'd0);
`ifdef DIV_CELL_REM_EN
        chk("abort_rem0", dif.A_div_rem, 32'd0);
`endif
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("abort_nodone", {31'd0, dif.A_div_done}, 32'd0);
            chk("abort_idle", {31'd0, dif.A_div_busy}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset            = 1'b1;
        dif.A_div_start  = 1'b0;
        dif.A_div_src1   = 32'd0;
        dif.A_div_src2   = 32'd0;
        dif.A_div_signed = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, dif.A_div_busy}, 32'd0);
        chk("rst_done", {31'd0, dif.A_div_done}, 32'd0);
        chk("rst_result", dif.A_div_result, 32'd0);
`ifdef DIV_CELL_REM_EN
        chk("rst_rem", dif.A_div_rem, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        do_div(32'd100, 32'd7, 1'b0, 0, 0);
        do_div(32'hFFFF_FF9C, 32'd7, 1'b1, 0, 0);
        do_div(32'd100, 32'hFFFF_FFF9, 1'b1, 0, 0);
        do_div(32'h0000_1234, 32'd0, 1'b1, 0, 0);
        do_div(32'h0000_1234, 32'd0, 1'b0, 0, 0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0);
        // Starts in cycles 5 and 35 must be ignored; next op starts in cycle 36
        do_div(32'd5000, 32'd33, 1'b0, 5, 35);
        do_div(32'hFFFF_EC78, 32'd3, 1'b1, 0, 0);

        for (int i = 0; i < 14; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i == 3) rb = 32'd0;
            do_div(ra, rb, 1'($urandom_range(0, 1)), 0, 0);
        end

        do_abort(32'd777, 32'd5, 1'b0);
        do_div(32'd1000, 32'd10, 1'b0, 0, 0);

        // Reset and start together: reset wins, start dropped
        dif.A_div_start = 1'b1;
        reset           = 1'b1;
        @(negedge clk);
        dif.A_div_start = 1'b0;
        reset           = 1'b0;
        chk("rststart_busy", {31'd0, dif.A_div_busy}, 32'd0);
        chk("rststart_res", dif.A_div_result, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rststart_idle", {31'd0, dif.A_div_busy}, 32'd0);
        end
        do_div(32'hFFFF_FC18, 32'd10, 1'b1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
